// File: rtl/move_check_dispatcher_if.sv
// Request/response bundle between game-play control and the move-check dispatcher.
// The master modport belongs to game-play control, the slave modport to the dispatcher.
interface move_check_dispatcher_if;
    logic       req_valid;
    logic       req_ready;
    logic [2:0] req_old_x;
    logic [2:0] req_old_y;
    logic [2:0] req_new_x;
    logic [2:0] req_new_y;
    logic       turn;
    logic       rsp_valid;
    logic       rsp_ready;
    logic       rsp_legal;
    logic [2:0] rsp_code;

    modport master (
        output req_valid, req_old_x, req_old_y, req_new_x, req_new_y, turn, rsp_ready,
        input  req_ready, rsp_valid, rsp_legal, rsp_code
    );

    modport slave (
        input  req_valid, req_old_x, req_old_y, req_new_x, req_new_y, turn, rsp_ready,
        output req_ready, rsp_valid, rsp_legal, rsp_code
    );
endinterface

// File: rtl/move_check_dispatcher.sv
// Dispatches one move request to its per-piece checker, pre-rejecting trivially illegal
// moves, and returns one latched verdict per request.
module move_check_dispatcher #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic                   clk,
    input  logic                   reset_n,
    move_check_dispatcher_if.slave bus,
    input  logic [7:0][7:0][3:0]   board_in,
    output logic [2:0]             old_x,
    output logic [2:0]             old_y,
    output logic [2:0]             new_x,
    output logic [2:0]             new_y,
    output logic [2:0]             h_delta,
    output logic [2:0]             v_delta,
    output logic [3:0]             piece_type,
    output logic [5:0]             chk_start,
    input  logic [5:0]             chk_valid_move,
    input  logic [5:0]             chk_valid_output
);

    typedef enum logic [2:0] {StIdle, StLookup, StIssue, StWait, StDone} state_e;

    state_e     state_q, state_d;
    logic [2:0] old_x_q, old_y_q, new_x_q, new_y_q;
    logic       turn_q;
    logic [3:0] piece_q, piece_d;
    logic [2:0] h_delta_q, h_delta_d, v_delta_q, v_delta_d;
    logic [7:0] cnt_q, cnt_d;
    logic       legal_q, legal_d;
    logic [2:0] code_q, code_d;

    logic       accept;
    logic [3:0] src, dst;
    logic [2:0] h_abs, v_abs;
    logic [5:0] sel_mask;
    logic       verdict_valid, verdict;

    // A borrowing subtract is negated back to a magnitude.
    function automatic logic [2:0] abs_diff(input logic [2:0] a, input logic [2:0] b);
        logic [3:0] d;
        d = {1'b0, a} - {1'b0, b};
        return d[3] ? (~d[2:0] + 3'd1) : d[2:0];
    endfunction

    assign accept = (state_q == StIdle) && bus.req_valid;
    assign src    = board_in[old_y_q][old_x_q];
    assign dst    = board_in[new_y_q][new_x_q];
    assign h_abs  = abs_diff(new_x_q, old_x_q);
    assign v_abs  = abs_diff(new_y_q, old_y_q);

    always_comb begin
        for (int i = 0; i < 6; i++) begin
            sel_mask[i] = (piece_q[2:0] == 3'(i + 1));
        end
    end

    // Only the selected checker's verdict is ever looked at.
    assign verdict_valid = |(chk_valid_output & sel_mask);
    assign verdict       = |(chk_valid_move & sel_mask);

    always_comb begin
        state_d   = state_q;
        piece_d   = piece_q;
        h_delta_d = h_delta_q;
        v_delta_d = v_delta_q;
        cnt_d     = cnt_q;
        legal_d   = legal_q;
        code_d    = code_q;
        unique case (state_q)
            StIdle: begin
                if (bus.req_valid) state_d = StLookup;
            end
            StLookup: begin
                piece_d   = src;
                h_delta_d = h_abs;
                v_delta_d = v_abs;
                legal_d   = 1'b0;
                code_d    = 3'd0;
                state_d   = StDone;
                if (h_abs == 3'd0 && v_abs == 3'd0)           code_d = 3'd5;
                else if (src[2:0] == 3'd0)                    code_d = 3'd2;
                else if (src[3] != turn_q)                    code_d = 3'd3;
                else if (dst[2:0] != 3'd0 && dst[3] == src[3]) code_d = 3'd4;
                else if (src[2:0] == 3'd7)                    code_d = 3'd7;
                else                                          state_d = StIssue;
            end
            StIssue: begin
                cnt_d   = 8'd0;
                state_d = StWait;
            end
            StWait: begin
                if (verdict_valid) begin
                    legal_d = verdict;
                    code_d  = verdict ? 3'd0 : 3'd1;
                    state_d = StDone;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                    if (cnt_d == 8'(TIMEOUT - 1)) begin
                        legal_d = 1'b0;
                        code_d  = 3'd6;
                        state_d = StDone;
                    end
                end
            end
            StDone: begin
                if (bus.rsp_ready) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= StIdle;
            old_x_q   <= 3'd0;
            old_y_q   <= 3'd0;
            new_x_q   <= 3'd0;
            new_y_q   <= 3'd0;
            turn_q    <= 1'b0;
            piece_q   <= 4'd0;
            h_delta_q <= 3'd0;
            v_delta_q <= 3'd0;
            cnt_q     <= 8'd0;
            legal_q   <= 1'b0;
            code_q    <= 3'd0;
        end else begin
            state_q   <= state_d;
            piece_q   <= piece_d;
            h_delta_q <= h_delta_d;
            v_delta_q <= v_delta_d;
            cnt_q     <= cnt_d;
            legal_q   <= legal_d;
            code_q    <= code_d;
            if (accept) begin
                old_x_q <= bus.req_old_x;
                old_y_q <= bus.req_old_y;
                new_x_q <= bus.req_new_x;
                new_y_q <= bus.req_new_y;
                turn_q  <= bus.turn;
            end
        end
    end

    assign bus.req_ready = (state_q == StIdle);
    assign bus.rsp_valid = (state_q == StDone);
    assign bus.rsp_legal = legal_q;
    assign bus.rsp_code  = code_q;
    assign chk_start     = (state_q == StIssue || state_q == StWait) ? sel_mask : 6'd0;
    assign old_x         = old_x_q;
    assign old_y         = old_y_q;
    assign new_x         = new_x_q;
    assign new_y         = new_y_q;
    assign h_delta       = h_delta_q;
    assign v_delta       = v_delta_q;
    assign piece_type    = piece_q;

endmodule

// File: tb/tb_move_check_dispatcher.sv
// Directed bench for move_check_dispatcher: knight dispatch, pre-rejects, deltas,
// timeout, backpressure and mid-operation reset.
module tb_move_check_dispatcher;

    logic                 clk = 1'b0;
    logic                 reset_n;
    logic [7:0][7:0][3:0] board;
    logic [2:0]           old_x, old_y, new_x, new_y, h_delta, v_delta;
    logic [3:0]           piece_type;
    logic [5:0]           chk_start, chk_valid_move, chk_valid_output;
    int                   total = 0;
    int                   bad = 0;
    int                   cyc;
    logic [5:0]           seen;

    typedef struct {
        logic [2:0] ox, oy, nx, ny;
        logic       t;
        logic [2:0] code;
    } pre_t;

    move_check_dispatcher_if bus ();

    move_check_dispatcher #(.TIMEOUT(16)) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .bus              (bus),
        .board_in         (board),
        .old_x            (old_x),
        .old_y            (old_y),
        .new_x            (new_x),
        .new_y            (new_y),
        .h_delta          (h_delta),
        .v_delta          (v_delta),
        .piece_type       (piece_type),
        .chk_start        (chk_start),
        .chk_valid_move   (chk_valid_move),
        .chk_valid_output (chk_valid_output)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [2:0] ox, input logic [2:0] oy, input logic [2:0] nx,
                        input logic [2:0] ny, input logic t);
        bus.req_old_x = ox;
        bus.req_old_y = oy;
        bus.req_new_x = nx;
        bus.req_new_y = ny;
        bus.turn      = t;
        bus.req_valid = 1'b1;
        @(negedge clk);
        bus.req_valid = 1'b0;
    endtask

    task automatic wait_rsp(output int n, output logic [5:0] s);
        n = 1;
        s = chk_start;
        while (!bus.rsp_valid && n < 64) begin
            @(negedge clk);
            n++;
            s |= chk_start;
        end
    endtask

    task automatic wait_start();
        int n = 0;
        while (chk_start == 6'd0 && n < 32) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic expect_rsp(input string tag, input logic legal, input logic [2:0] code);
        chk({tag, "_rsp_valid"}, 32'(bus.rsp_valid), 32'd1);
        chk({tag, "_rsp_legal"}, 32'(bus.rsp_legal), 32'(legal));
        chk({tag, "_rsp_code"}, 32'(bus.rsp_code), 32'(code));
    endtask

    task automatic ack();
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        bus.rsp_ready = 1'b0;
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_req_ready"}, 32'(bus.req_ready), 32'd1);
        chk({tag, "_rsp_valid"}, 32'(bus.rsp_valid), 32'd0);
        chk({tag, "_rsp_legal"}, 32'(bus.rsp_legal), 32'd0);
        chk({tag, "_rsp_code"}, 32'(bus.rsp_code), 32'd0);
        chk({tag, "_chk_start"}, 32'(chk_start), 32'd0);
        chk({tag, "_coords"}, 32'({old_x, old_y, new_x, new_y}), 32'd0);
        chk({tag, "_deltas"}, 32'({h_delta, v_delta}), 32'd0);
        chk({tag, "_piece"}, 32'(piece_type), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "bench timeout");
    end

    initial begin
        pre_t pre [5];
        reset_n          = 1'b0;
        board            = '0;
        bus.req_valid    = 1'b0;
        bus.req_old_x    = 3'd0;
        bus.req_old_y    = 3'd0;
        bus.req_new_x    = 3'd0;
        bus.req_new_y    = 3'd0;
        bus.turn         = 1'b0;
        bus.rsp_ready    = 1'b0;
        chk_valid_move   = 6'd0;
        chk_valid_output = 6'd0;
        board[0][1] = 4'h2;  // white knight b1
        board[7][4] = 4'hC;  // black rook
        board[1][3] = 4'h1;  // white pawn
        board[6][6] = 4'h7;  // reserved code
        board[0][7] = 4'h5;  // white queen
        board[3][3] = 4'h6;  // white king

        repeat (2) @(negedge clk);
        check_reset_vals("reset");
        reset_n = 1'b1;
        @(negedge clk);

        // Knight b1-c3, checker answers two cycles into the level start.
        send(3'd1, 3'd0, 3'd2, 3'd2, 1'b0);
        wait_start();
        chk("knight_start", 32'(chk_start), 32'b000010);
        chk("knight_deltas", 32'({h_delta, v_delta}), 32'({3'd1, 3'd2}));
        chk("knight_piece", 32'(piece_type), 32'h2);
        chk("knight_coords", 32'({old_x, old_y, new_x, new_y}), 32'({3'd1, 3'd0, 3'd2, 3'd2}));
        repeat (2) @(negedge clk);
        chk_valid_output = 6'b000010;
        chk_valid_move   = 6'b000010;
        wait_rsp(cyc, seen);
        chk_valid_output = 6'd0;
        chk_valid_move   = 6'd0;
        expect_rsp("knight", 1'b1, 3'd0);
        chk("knight_done_start", 32'(chk_start), 32'd0);
        ack();
        chk("knight_ready_back", 32'(bus.req_ready), 32'd1);

        pre[0] = '{ox: 3'd5, oy: 3'd5, nx: 3'd5, ny: 3'd6, t: 1'b0, code: 3'd2};
        pre[1] = '{ox: 3'd4, oy: 3'd7, nx: 3'd4, ny: 3'd5, t: 1'b0, code: 3'd3};
        pre[2] = '{ox: 3'd1, oy: 3'd0, nx: 3'd3, ny: 3'd1, t: 1'b0, code: 3'd4};
        pre[3] = '{ox: 3'd1, oy: 3'd0, nx: 3'd1, ny: 3'd0, t: 1'b0, code: 3'd5};
        pre[4] = '{ox: 3'd6, oy: 3'd6, nx: 3'd6, ny: 3'd5, t: 1'b0, code: 3'd7};
        for (int i = 0; i < 5; i++) begin
            send(pre[i].ox, pre[i].oy, pre[i].nx, pre[i].ny, pre[i].t);
            wait_rsp(cyc, seen);
            expect_rsp($sformatf("pre%0d", i), 1'b0, pre[i].code);
            chk($sformatf("pre%0d_latency", i), 32'(cyc), 32'd2);
            chk($sformatf("pre%0d_no_start", i), 32'(seen), 32'd0);
            ack();
        end

        // Queen h1-a8: deltas 7/7, selected checker rejects, other bits are noise.
        send(3'd7, 3'd0, 3'd0, 3'd7, 1'b0);
        wait_start();
        chk("queen_start", 32'(chk_start), 32'b010000);
        chk("queen_deltas", 32'({h_delta, v_delta}), 32'({3'd7, 3'd7}));
        chk_valid_output = 6'b111111;
        chk_valid_move   = 6'b101111;
        wait_rsp(cyc, seen);
        chk_valid_output = 6'd0;
        chk_valid_move   = 6'd0;
        expect_rsp("queen", 1'b0, 3'd1);
        ack();

        send(3'd3, 3'd3, 3'd4, 3'd2, 1'b0);
        wait_start();
        chk("king_start", 32'(chk_start), 32'b100000);
        chk("king_deltas", 32'({h_delta, v_delta}), 32'({3'd1, 3'd1}));
        chk_valid_output = 6'b100000;
        chk_valid_move   = 6'b100000;
        wait_rsp(cyc, seen);
        chk_valid_output = 6'd0;
        chk_valid_move   = 6'd0;
        expect_rsp("king", 1'b1, 3'd0);
        ack();

        // Silent checker: timeout, then backpressure with a queued request.
        send(3'd1, 3'd0, 3'd2, 3'd2, 1'b0);
        wait_rsp(cyc, seen);
        chk("timeout_latency", 32'(cyc), 32'd18);
        expect_rsp("timeout", 1'b0, 3'd6);
        chk("timeout_done_start", 32'(chk_start), 32'd0);
        bus.req_old_x = 3'd1;
        bus.req_old_y = 3'd0;
        bus.req_new_x = 3'd1;
        bus.req_new_y = 3'd0;
        bus.req_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            chk($sformatf("bp%0d_hold", i),
                32'({bus.rsp_valid, bus.rsp_legal, bus.rsp_code, bus.req_ready}),
                32'({1'b1, 1'b0, 3'd6, 1'b0}));
            @(negedge clk);
        end
        ack();
        chk("bp_idle_ready", 32'(bus.req_ready), 32'd1);
        @(negedge clk);
        bus.req_valid = 1'b0;
        chk("bp_next_accepted", 32'(bus.req_ready), 32'd0);
        @(negedge clk);
        expect_rsp("bp_next", 1'b0, 3'd5);
        ack();

        // Asynchronous reset while waiting on the checker.
        send(3'd1, 3'd0, 3'd2, 3'd2, 1'b0);
        wait_start();
        repeat (2) @(negedge clk);
        #1 reset_n = 1'b0;
        #1 check_reset_vals("wait_reset");
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        send(3'd1, 3'd0, 3'd2, 3'd2, 1'b0);
        wait_start();
        chk("post_reset_start", 32'(chk_start), 32'b000010);
        chk_valid_output = 6'b000010;
        chk_valid_move   = 6'b000010;
        wait_rsp(cyc, seen);
        chk_valid_output = 6'd0;
        chk_valid_move   = 6'd0;
        expect_rsp("post_reset", 1'b1, 3'd0);
        ack();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
